sprite_eval_ctrl: RTL and testbench
===================================

SPRITE_EVAL_CTRL -- requirements
Module: sprite_eval_ctrl

Interface
REQ-001 Parameter OAM_SPRITES, default 64: number of sprite entries in primary OAM, 4 bytes each.
REQ-002 Parameter SEC_SLOTS, default 8: number of secondary-OAM slots feeding the sprite priority decode.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ppu_ctrl_1  in  8  bit 5 = sprite size (0: 8 rows, 1: 16 rows).
REQ-007 ppu_ctrl_2  in  8  bit 4 = sprite enable.
REQ-008 scanline_start  in  1  one-cycle pulse requesting evaluation for the next line.
REQ-009 scanline  in  9  target line; held stable while eval_busy=1.
REQ-010 oam_addr  out  8  primary OAM byte address; synchronous RAM with 1-cycle read latency.
REQ-011 oam_rdata  in  8  primary OAM read data.
REQ-012 sec_we  out  1  secondary OAM write strobe.
REQ-013 sec_addr  out  5  secondary OAM byte address (slot*4 + byte).
REQ-014 sec_wdata  out  8  secondary OAM write data.
REQ-015 eval_busy  out  1  high from the cycle after scanline_start until DONE.
REQ-016 eval_done  out  1  one-cycle pulse when results are valid.
REQ-017 sprite_count  out  4  number of sprites copied (0..8).
REQ-018 sprite_overflow  out  1  more than SEC_SLOTS sprites are in range.
REQ-019 sprite0_in_line  out  1  OAM sprite 0 was copied into slot 0.

Function
REQ-020 FSM states: IDLE, CLEAR, READ_Y, CHECK_Y, COPY, DONE; DONE lasts one cycle, then the FSM returns to IDLE.
REQ-021 scanline_start in any state: the FSM enters CLEAR the next cycle, with n=0, count=0, overflow=0 and sprite0_in_line=0 (a pulse while busy aborts and restarts the evaluation).
REQ-022 CLEAR: 32 cycles, writing 0xFF to sec_addr 0..31 in ascending order, sec_we=1 each cycle.
REQ-023 After CLEAR with ppu_ctrl_2[4]=0: the FSM goes to DONE; no OAM reads occur.
REQ-024 After CLEAR with ppu_ctrl_2[4]=1: the FSM goes to READ_Y.
REQ-025 READ_Y: oam_addr=4n.
REQ-026 CHECK_Y: oam_rdata=Y; oam_addr=4n+1.
REQ-027 In-range test: {1'b0,Y} <= scanline and (scanline - {1'b0,Y}) < H, computed 9-bit unsigned; H=16 if ppu_ctrl_1[5] else 8.
REQ-028 In range and count<8: write Y to sec_addr=4*count in CHECK_Y, then enter COPY with k=1.
REQ-029 In range and count=8: set sprite_overflow=1 and go to DONE; no write occurs.
REQ-030 Not in range: n increments; the FSM goes to READ_Y, or to DONE if n was OAM_SPRITES-1.
REQ-031 COPY k (1..3): write oam_rdata to sec_addr=4*count+k; oam_addr=4n+k+1. After k=3, count increments, n increments, and the FSM goes to READ_Y, or to DONE if n was OAM_SPRITES-1.
REQ-032 Timing per sprite: 2 cycles when rejected, 5 cycles when copied. Worst case (8 hits) is 1+32+8*5+56*2+1 = 186 cycles from scanline_start to eval_done.
REQ-033 sprite0_in_line is set when n=0 passes the test with count=0.
REQ-034 Copied sprites keep ascending OAM order in the slots (lower slot = higher priority).
REQ-035 sprite_count, sprite_overflow and sprite0_in_line hold their values from eval_done until the next scanline_start.
REQ-036 sec_we=0 in IDLE, READ_Y, DONE and on a rejected CHECK_Y.
REQ-037 Y=0xFF with scanline 0..239 is never in range; Y+H past 255 is handled by the 9-bit arithmetic and does not wrap.

Reset
REQ-038 rst_n low forces IDLE asynchronously at any time, including mid-evaluation.
REQ-039 Reset values: oam_addr=0, sec_we=0, sec_addr=0, sec_wdata=0, eval_busy=0, eval_done=0, sprite_count=0, sprite_overflow=0, sprite0_in_line=0.
REQ-040 Secondary OAM contents are not restored by reset; the next CLEAR re-initialises them.

Structure
REQ-041 Package ppu_pkg holds: FSM state enum, OAM_BYTES=256, SEC_BYTES=32, SPR_H_8=8, SPR_H_16=16, and the ppu_ctrl bit indices (SPR_SIZE_BIT=5, SPR_EN_BIT=4).
REQ-042 One sub-module, sprite_range_check (inputs Y, scanline, size; output in_range), is used combinationally in CHECK_Y.

Verification
REQ-043 Scenario 1: sprites enabled, 8x8 size, scanline=20; OAM sprites 0,5,9 have Y=15,20,13 and all other Y=0xFF -> count=3, slots 0..2 hold sprites 0,5,9, sprite0_in_line=1, overflow=0, eval_done at cycle 33+64*2+3*3+1 relative to the pulse.
REQ-044 Scenario 2: ten sprites with Y=100 (n=2..11), scanline=104 -> slots hold n=2..9, count=8, overflow=1, DONE entered on n=10.
REQ-045 Scenario 3: ppu_ctrl_1[5]=1, sprite 3 has Y=50, scanline=65 -> copied; scanline=66 -> not copied; with 8x8 size, scanline=58 -> not copied.
REQ-046 Scenario 4: ppu_ctrl_2[4]=0 -> exactly 32 writes of 0xFF, no oam_addr activity beyond its reset value, count=0, eval_done 34 cycles after the pulse.
REQ-047 Scenario 5: rst_n asserted during COPY of sprite 4 -> all outputs at reset values immediately; the next scanline_start yields a clean full evaluation.
REQ-048 Scenario 6: second scanline_start at cycle 50 of an evaluation -> restart; CLEAR rewrites all 32 bytes; results match a single evaluation of the new scanline.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sprite evaluation logic.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_READ_Y,
    ST_CHECK_Y,
    ST_COPY,
    ST_DONE
  } eval_state_e;

  localparam int unsigned OAM_BYTES    = 256;
  localparam int unsigned SEC_BYTES    = 32;
  localparam int unsigned SPR_H_8      = 8;
  localparam int unsigned SPR_H_16     = 16;
  localparam int unsigned SPR_SIZE_BIT = 5;
  localparam int unsigned SPR_EN_BIT   = 4;

endpackage

// File: rtl/sprite_range_check.sv
// Decides whether a sprite with top row Y covers the target scanline.
module sprite_range_check
  import ppu_pkg::*;
(
  input  logic [7:0] y,
  input  logic [8:0] scanline,
  input  logic       size,
  output logic       in_range
);

  logic [8:0] y_ext;
  logic [8:0] diff;
  logic [8:0] height;

  // 9-bit arithmetic so Y near 255 never wraps back onto low scanlines
  assign y_ext    = {1'b0, y};
  assign diff     = scanline - y_ext;
  assign height   = size ? 9'(SPR_H_16) : 9'(SPR_H_8);
  assign in_range = (y_ext <= scanline) && (diff < height);

endmodule

// File: rtl/sprite_eval_ctrl.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM and
// copies up to SEC_SLOTS in-range sprites in ascending OAM order.
module sprite_eval_ctrl
  import ppu_pkg::*;
#(
  parameter int unsigned OAM_SPRITES = 64,
  parameter int unsigned SEC_SLOTS   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ppu_ctrl_1,
  input  logic [7:0] ppu_ctrl_2,
  input  logic       scanline_start,
  input  logic [8:0] scanline,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_rdata,
  output logic       sec_we,
  output logic [4:0] sec_addr,
  output logic [7:0] sec_wdata,
  output logic       eval_busy,
  output logic       eval_done,
  output logic [3:0] sprite_count,
  output logic       sprite_overflow,
  output logic       sprite0_in_line
);

  localparam int unsigned N_W   = (OAM_SPRITES > 1) ? $clog2(OAM_SPRITES) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CLR_W = 5;

  eval_state_e      state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CLR_W-1:0] clr_q, clr_d;
  logic             overflow_q, overflow_d;
  logic             spr0_q, spr0_d;
  logic [7:0]       oam_addr_q, oam_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             in_range;
  logic             last_spr;
  logic             spr_en;
  logic [7:0]       base_addr;
  logic             unused_ctrl;

  assign spr_en      = ppu_ctrl_2[SPR_EN_BIT];
  assign last_spr    = (n_q == N_W'(OAM_SPRITES - 1));
  assign unused_ctrl = ^{ppu_ctrl_1, ppu_ctrl_2};

  sprite_range_check u_range (
    .y        (oam_rdata),
    .scanline (scanline),
    .size     (ppu_ctrl_1[SPR_SIZE_BIT]),
    .in_range (in_range)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      count_q    <= '0;
      clr_q      <= '0;
      overflow_q <= 1'b0;
      spr0_q     <= 1'b0;
      oam_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      count_q    <= count_d;
      clr_q      <= clr_d;
      overflow_q <= overflow_d;
      spr0_q     <= spr0_d;
      oam_addr_q <= oam_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, counters and secondary OAM write port
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    count_d    = count_q;
    clr_d      = clr_q;
    overflow_d = overflow_q;
    spr0_d     = spr0_q;
    sec_we     = 1'b0;
    sec_addr   = '0;
    sec_wdata  = '0;
    oam_addr_d = '0;
    base_addr  = '0;

    case (state_q)
      ST_IDLE: ;
      ST_CLEAR: begin
        sec_we    = 1'b1;
        sec_addr  = clr_q;
        sec_wdata = 8'hFF;
        clr_d     = clr_q + CLR_W'(1);
        if (clr_q == CLR_W'(SEC_BYTES - 1)) begin
          state_d = spr_en ? ST_READ_Y : ST_DONE;
        end
      end
      ST_READ_Y: state_d = ST_CHECK_Y;
      ST_CHECK_Y: begin
        if (in_range) begin
          if (count_q < CNT_W'(SEC_SLOTS)) begin
            sec_we    = 1'b1;
            sec_addr  = 5'({count_q, 2'b00});
            sec_wdata = oam_rdata;
            k_d       = 2'd1;
            state_d   = ST_COPY;
            if (n_q == '0 && count_q == '0) spr0_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
            state_d    = ST_DONE;
          end
        end else begin
          n_d     = n_q + N_W'(1);
          state_d = last_spr ? ST_DONE : ST_READ_Y;
        end
      end
      ST_COPY: begin
        sec_we    = 1'b1;
        sec_addr  = 5'({count_q, k_q});
        sec_wdata = oam_rdata;
        k_d       = k_q + 2'd1;
        if (k_q == 2'd3) begin
          count_d = count_q + CNT_W'(1);
          n_d     = n_q + N_W'(1);
          state_d = last_spr ? ST_DONE : ST_READ_Y;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new request wins over anything in flight
    if (scanline_start) begin
      state_d    = ST_CLEAR;
      n_d        = '0;
      count_d    = '0;
      clr_d      = '0;
      overflow_d = 1'b0;
      spr0_d     = 1'b0;
    end

    // OAM address is registered one cycle ahead of the byte it fetches
    base_addr = 8'({n_d, 2'b00});
    case (state_d)
      ST_READ_Y:  oam_addr_d = base_addr;
      ST_CHECK_Y: oam_addr_d = base_addr + 8'd1;
      ST_COPY:    oam_addr_d = base_addr + 8'(k_d) + 8'd1;
      default:    oam_addr_d = '0;
    endcase

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_READ_Y) ||
             (state_d == ST_CHECK_Y) || (state_d == ST_COPY);
    done_d = (state_d == ST_DONE);
  end

  assign oam_addr        = oam_addr_q;
  assign eval_busy       = busy_q;
  assign eval_done       = done_q;
  assign sprite_count    = count_q;
  assign sprite_overflow = overflow_q;
  assign sprite0_in_line = spr0_q;

endmodule

// File: tb/tb_sprite_eval_ctrl.sv
// Scoreboard bench for sprite_eval_ctrl: a loop-level reference model predicts
// each evaluation; a monitor checks results whenever eval_done fires.
module tb_sprite_eval_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] ppu_ctrl_1;
  logic [7:0] ppu_ctrl_2;
  logic       scanline_start;
  logic [8:0] scanline;
  logic [7:0] oam_addr;
  logic [7:0] oam_rdata;
  logic       sec_we;
  logic [4:0] sec_addr;
  logic [7:0] sec_wdata;
  logic       eval_busy;
  logic       eval_done;
  logic [3:0] sprite_count;
  logic       sprite_overflow;
  logic       sprite0_in_line;

  typedef struct packed {
    logic [3:0]   cnt;
    logic         ovf;
    logic         s0;
    logic [7:0]   lat;
    logic [7:0]   wr;
    logic         act;
    logic [255:0] sec;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          lat = 0;
  int          wr_cnt = 0;
  logic        oam_act = 1'b0;
  logic [255:0] sec_img = '0;
  logic [7:0]  oam_mem [256];
  exp_t        exp_q[$];
  exp_t        last_exp;

  sprite_eval_ctrl #(.OAM_SPRITES(64), .SEC_SLOTS(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ppu_ctrl_1      (ppu_ctrl_1),
    .ppu_ctrl_2      (ppu_ctrl_2),
    .scanline_start  (scanline_start),
    .scanline        (scanline),
    .oam_addr        (oam_addr),
    .oam_rdata       (oam_rdata),
    .sec_we          (sec_we),
    .sec_addr        (sec_addr),
    .sec_wdata       (sec_wdata),
    .eval_busy       (eval_busy),
    .eval_done       (eval_done),
    .sprite_count    (sprite_count),
    .sprite_overflow (sprite_overflow),
    .sprite0_in_line (sprite0_in_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Primary OAM: synchronous RAM, one-cycle read latency
  always @(posedge clk) oam_rdata <= oam_mem[oam_addr];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Reference: walk OAM in order, copy the first 8 hits, flag a ninth
  function automatic exp_t model(input logic en, input logic big, input logic [8:0] line);
    exp_t e;
    int h, hits, cyc, y, ln;
    e = '0;
    e.sec = '1;
    h = big ? 16 : 8;
    hits = 0;
    cyc = 34;
    ln = int'(line);
    if (en) begin
      for (int s = 0; s < 64; s++) begin
        y = int'(oam_mem[4*s]);
        cyc += 2;
        if (ln >= y && (ln - y) < h) begin
          if (hits == 8) begin
            e.ovf = 1'b1;
            break;
          end
          for (int b = 0; b < 4; b++) e.sec[(hits*4+b)*8 +: 8] = oam_mem[4*s+b];
          if (s == 0) e.s0 = 1'b1;
          hits++;
          cyc += 3;
        end
      end
    end
    e.cnt = 4'(hits);
    e.lat = 8'(cyc);
    e.wr  = 8'(32 + 4*hits);
    e.act = en;
    return e;
  endfunction

  // Monitor: capture secondary OAM writes, score each completed evaluation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sec_we) begin
        sec_img[int'(sec_addr)*8 +: 8] = sec_wdata;
        wr_cnt++;
      end
      if (oam_addr != 8'd0) oam_act = 1'b1;
      if (scanline_start) begin
        wr_cnt = 0;
        oam_act = 1'b0;
        lat = 1;
      end else begin
        lat++;
      end
      if (eval_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got=1 want=0");
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          chk("count",    256'(sprite_count),    256'(e.cnt));
          chk("overflow", 256'(sprite_overflow), 256'(e.ovf));
          chk("sprite0",  256'(sprite0_in_line), 256'(e.s0));
          chk("latency",  256'(lat),             256'(e.lat));
          chk("sec_wr",   256'(wr_cnt),          256'(e.wr));
          chk("oam_act",  256'(oam_act),         256'(e.act));
          chk("sec_oam",  sec_img,               e.sec);
        end
        done_cnt++;
      end
    end
  end

  task automatic start_eval(input logic en, input logic big, input logic [8:0] line);
    ppu_ctrl_1 = {2'b00, big, 5'b00000};
    ppu_ctrl_2 = {3'b000, en, 4'b0000};
    scanline = line;
    exp_q.push_back(model(en, big, line));
    scanline_start = 1'b1;
    @(posedge clk);
    #1 scanline_start = 1'b0;
    chk("busy_after_start", 256'(eval_busy), 256'(1));
  endtask

  task automatic wait_done();
    int target;
    bit seen;
    target = done_cnt + 1;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        seen = 1;
        break;
      end
    end
    #1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout got=no_done want=eval_done");
    end else begin
      repeat (3) @(posedge clk);
      #1;
      chk("hold_count", 256'(sprite_count),    256'(last_exp.cnt));
      chk("hold_ovf",   256'(sprite_overflow), 256'(last_exp.ovf));
      chk("idle_busy",  256'(eval_busy),       256'(0));
    end
  endtask

  task automatic blank_oam();
    for (int s = 0; s < 64; s++) begin
      oam_mem[4*s] = 8'hFF;
      for (int b = 1; b < 4; b++) oam_mem[4*s+b] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic random_oam(input int line);
    int y;
    for (int s = 0; s < 64; s++) begin
      case ($urandom_range(0, 3))
        0: y = 255;
        1: y = int'($urandom_range(0, 255));
        default: begin
          y = line - int'($urandom_range(0, 17));
          if (y < 0) y = 255;
        end
      endcase
      oam_mem[4*s] = 8'(y);
      for (int b = 1; b < 4; b++) oam_mem[4*s+b] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oam_addr"},  256'(oam_addr),        256'(0));
    chk({tag, "_sec_we"},    256'(sec_we),          256'(0));
    chk({tag, "_sec_addr"},  256'(sec_addr),        256'(0));
    chk({tag, "_sec_wdata"}, 256'(sec_wdata),       256'(0));
    chk({tag, "_busy"},      256'(eval_busy),       256'(0));
    chk({tag, "_done"},      256'(eval_done),       256'(0));
    chk({tag, "_count"},     256'(sprite_count),    256'(0));
    chk({tag, "_ovf"},       256'(sprite_overflow), 256'(0));
    chk({tag, "_s0"},        256'(sprite0_in_line), 256'(0));
  endtask

  initial begin
    bit hit;
    int line;
    rst_n = 1'b0;
    ppu_ctrl_1 = '0;
    ppu_ctrl_2 = '0;
    scanline_start = 1'b0;
    scanline = '0;
    blank_oam();
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three scattered hits, sprite 0 among them
    blank_oam();
    oam_mem[0] = 8'd15;
    oam_mem[20] = 8'd20;
    oam_mem[36] = 8'd13;
    start_eval(1'b1, 1'b0, 9'd20);
    wait_done();

    // Ten hits: eight copied, ninth raises overflow
    blank_oam();
    for (int s = 2; s < 12; s++) oam_mem[4*s] = 8'd100;
    start_eval(1'b1, 1'b0, 9'd104);
    wait_done();

    // Height boundaries for 8x16 and 8x8
    blank_oam();
    oam_mem[12] = 8'd50;
    start_eval(1'b1, 1'b1, 9'd65);
    wait_done();
    start_eval(1'b1, 1'b1, 9'd66);
    wait_done();
    start_eval(1'b1, 1'b0, 9'd58);
    wait_done();

    // Y near the top of the range must not wrap onto low lines
    blank_oam();
    oam_mem[4] = 8'd250;
    start_eval(1'b1, 1'b1, 9'd3);
    wait_done();

    // Sprites disabled: clear only
    start_eval(1'b0, 1'b0, 9'd20);
    wait_done();

    // Asynchronous reset in the middle of copying sprite 4 (slot 2)
    blank_oam();
    oam_mem[0] = 8'd30;
    oam_mem[8] = 8'd30;
    oam_mem[16] = 8'd30;
    start_eval(1'b1, 1'b0, 9'd33);
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sec_we && sec_addr == 5'd10) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL copy4_wait got=no_write want=sec_addr_10");
    end
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_eval(1'b1, 1'b0, 9'd33);
    wait_done();

    // Restart at cycle 50 of an evaluation with a new scanline
    random_oam(120);
    start_eval(1'b1, 1'b0, 9'd120);
    repeat (48) @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    start_eval(1'b1, 1'b1, 9'd118);
    wait_done();

    // Randomized evaluations
    for (int r = 0; r < 20; r++) begin
      line = int'($urandom_range(0, 239));
      random_oam(line);
      start_eval(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 9'(line));
      wait_done();
    end

    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
